gemm_tile_sequencer: RTL
========================

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL have parameters: TILE, default 8, tile edge in elements, power of 2 in 2..64; DIM_W, default 16, dimension width; SP_AW, default 14, scratchpad address width; TMO_W, default 20, watchdog counter width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin job, sampled in IDLE only
- abort  in  1  cancel job
- a_base, b_base, c_base  in  32 each  matrix byte base addresses
- m_dim, k_dim, n_dim  in  DIM_W each  matrix dimensions in elements
- stride_a, stride_b, stride_c  in  16 each  row pitch in bytes
- busy  out  1  job active
- done  out  1  one-cycle completion pulse
- error  out  1  sticky error flag
- err_code  out  2  error cause: 0 none, 1 dim, 2 dma, 3 timeout/abort
- dma_req  out  1  command valid
- dma_ack  in  1  command accepted
- dma_dir  out  1  0 = mem->sp, 1 = sp->mem
- dma_mem_addr  out  32  memory address
- dma_sp_addr  out  SP_AW  scratchpad address
- dma_len  out  16  rows to transfer
- dma_stride  out  16  row pitch
- dma_done  in  1  transfer complete pulse
- dma_err  in  1  transfer error pulse
- comp_start  out  1  compute pulse
- comp_clear  out  1  clear accumulators, with first k-tile
- comp_done  in  1  compute complete pulse
- tile_m, tile_n, tile_k  out  DIM_W each  current tile indices

Function
REQ-003 SHALL latch all config inputs on start in IDLE; later config changes SHALL NOT affect the running job.
REQ-004 SHALL compute tile counts MT = ceil(m/TILE), NT = ceil(n/TILE), KT = ceil(k/TILE) by shift, with no divider.
REQ-005 States: IDLE, LOAD_A, LOAD_B, COMPUTE, STORE_C, DONE, ERR.
- LOAD_A, LOAD_B and STORE_C each have an ISSUE sub-phase and a WAIT sub-phase.
REQ-006 SHALL iterate the loop order mi outer, ni middle, ki inner.
- Per ki: LOAD_A -> LOAD_B -> COMPUTE.
- After the last ki: STORE_C.
- Then ni++ (wrapping to 0 with mi++); DONE after the last (mi, ni).
REQ-007 ISSUE SHALL hold dma_req=1 with stable fields until the cycle dma_ack=1, then move to WAIT; dma_req SHALL drop the cycle after acceptance.
REQ-008 WAIT SHALL advance on dma_done; dma_err in WAIT SHALL go to ERR with err_code=2.
REQ-009 Address generation, 32-bit wraparound:
- A tile = a_base + mi*TILE*stride_a + ki*TILE.
- B tile = b_base + ki*TILE*stride_b + ni*TILE.
- C tile = c_base + mi*TILE*stride_c + ni*TILE*4.
REQ-010 dma_len = TILE for all transfers. Scratchpad addresses: A = 0; B = 2^(SP_AW-1); C = 2^(SP_AW-2).
REQ-011 comp_start SHALL pulse 1 cycle on COMPUTE entry; comp_clear SHALL pulse with it only when ki=0. COMPUTE SHALL exit on comp_done.
REQ-012 Zero dimension at start SHALL go IDLE->ERR (err_code=1) with no DMA issued.
REQ-013 DONE SHALL last 1 cycle: done=1, busy=0 next, return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE; ERR SHALL return to IDLE after 1 cycle.
REQ-015 abort in any non-IDLE state SHALL, within 1 cycle: drop dma_req, go to ERR, set err_code=3. abort in IDLE SHALL be ignored.
REQ-016 start while busy SHALL be ignored.
REQ-017 start in IDLE SHALL clear error and err_code.

Reset
REQ-018 While rst_n=0: state IDLE; all outputs 0; tile indices 0; latched config 0.
REQ-019 Reset mid-transfer SHALL drop dma_req immediately; no done pulse.

Configuration
REQ-020 Macro GEMM_SEQ_TIMEOUT_EN, when defined:
- A TMO_W-bit watchdog counts cycles in each WAIT/COMPUTE phase and resets on every phase change.
- On saturation: go to ERR with err_code=3.
REQ-021 Without GEMM_SEQ_TIMEOUT_EN: no watchdog logic; waits are unbounded.

Verification
REQ-022 m=k=n=8, TILE=8, ack/done 2 cycles after req -> exactly one each of A, B, compute, C; comp_clear=1; one done pulse.
REQ-023 m=16, n=16, k=24 -> 4 C stores, 12 computes, 12 A loads; tile 3 C addr = c_base + 8*stride_c + 32.
REQ-024 dma_ack held 0 for 10 cycles -> dma_req and fields stable for all 10 cycles.
REQ-025 dma_err during LOAD_B of tile 0 -> error=1, err_code=2, no done, IDLE after 1 cycle.
REQ-026 k_dim=0 -> err_code=1, dma_req never asserted. abort during COMPUTE -> err_code=3, busy=0 within 2 cycles.
REQ-027 With GEMM_SEQ_TIMEOUT_EN, TMO_W=4, comp_done withheld -> ERR, err_code=3, after 15 cycles.

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer
//   Walks a tiled GEMM C[m x n] += A[m x k] * B[k x n] over TILE x TILE tiles.
//   Loop order: mi (outer), ni (middle), ki (inner). For each ki it loads an
//   A tile, then a B tile, then runs the compute engine. After the last ki of
//   an (mi, ni) pair it stores the C tile. All DMA commands move TILE rows.
//
//   Optional feature: define GEMM_SEQ_TIMEOUT_EN to add a TMO_W-bit watchdog
//   over every WAIT / COMPUTE phase. A phase that runs too long ends the job
//   with err_code = 3. Without the macro, waits are unbounded.
//
// Parameters
//   TILE   tile edge in elements (power of 2, 2..64)
//   DIM_W  width of the dimension inputs and tile indices
//   SP_AW  scratchpad address width
//   TMO_W  watchdog counter width (used only with GEMM_SEQ_TIMEOUT_EN)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               job control (start only sampled in IDLE)
//   a/b/c_base, m/k/n_dim,
//   stride_a/b/c               job configuration, latched on an accepted start
//   busy, done, error,
//   err_code                   status (err_code: 0 none, 1 dim, 2 dma, 3 abort/timeout)
//   dma_req/ack, dma_dir,
//   dma_mem_addr, dma_sp_addr,
//   dma_len, dma_stride,
//   dma_done, dma_err          DMA command channel and completion
//   comp_start, comp_clear,
//   comp_done                  compute engine handshake
//   tile_m, tile_n, tile_k     current tile indices
module gemm_tile_sequencer #(
  parameter int TILE  = 8,
  parameter int DIM_W = 16,
  parameter int SP_AW = 14,
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      a_base,
  input  logic [31:0]      b_base,
  input  logic [31:0]      c_base,
  input  logic [DIM_W-1:0] m_dim,
  input  logic [DIM_W-1:0] k_dim,
  input  logic [DIM_W-1:0] n_dim,
  input  logic [15:0]      stride_a,
  input  logic [15:0]      stride_b,
  input  logic [15:0]      stride_c,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             dma_req,
  input  logic             dma_ack,
  output logic             dma_dir,
  output logic [31:0]      dma_mem_addr,
  output logic [SP_AW-1:0] dma_sp_addr,
  output logic [15:0]      dma_len,
  output logic [15:0]      dma_stride,
  input  logic             dma_done,
  input  logic             dma_err,
  output logic             comp_start,
  output logic             comp_clear,
  input  logic             comp_done,
  output logic [DIM_W-1:0] tile_m,
  output logic [DIM_W-1:0] tile_n,
  output logic [DIM_W-1:0] tile_k
);

  localparam int LOG2T = $clog2(TILE);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DIM   = 2'd1;
  localparam logic [1:0] ERR_DMA   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  // Scratchpad layout: A at the bottom, C at one quarter, B at one half.
  localparam logic [SP_AW-1:0] SP_A = '0;
  localparam logic [SP_AW-1:0] SP_B = SP_AW'(1) << (SP_AW - 1);
  localparam logic [SP_AW-1:0] SP_C = SP_AW'(1) << (SP_AW - 2);
  localparam logic [15:0]      LEN  = 16'(TILE);

  // Each DMA phase is split into ISSUE (request held until ack) and WAIT
  // (waiting for the transfer-complete pulse).
  typedef enum logic [3:0] {
    IDLE,
    LOAD_A_ISSUE,
    LOAD_A_WAIT,
    LOAD_B_ISSUE,
    LOAD_B_WAIT,
    COMPUTE,
    STORE_C_ISSUE,
    STORE_C_WAIT,
    DONE,
    ERR
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched job configuration
  logic [31:0]      r_a_base, r_b_base, r_c_base;
  logic [15:0]      r_stride_a, r_stride_b, r_stride_c;
  logic [DIM_W-1:0] r_mt, r_nt, r_kt;

  // Tile indices and status
  logic [DIM_W-1:0] r_mi, r_ni, r_ki;
  logic [DIM_W-1:0] w_mi_next, w_ni_next, w_ki_next;
  logic             r_error, w_error_next;
  logic [1:0]       r_err_code, w_err_code_next;
  logic             r_comp_start, r_comp_clear;
  logic             w_latch;
  logic             w_enter_compute;
  logic             w_tmo;

  // ceil(d / TILE) without a divider: whole tiles plus one if any remainder.
  function automatic logic [DIM_W-1:0] ceil_tiles(input logic [DIM_W-1:0] d);
    return (d >> LOG2T) + {{(DIM_W-1){1'b0}}, |d[LOG2T-1:0]};
  endfunction

  // ---------------------------------------------------------------------
  // Address generation (32-bit wraparound is intended)
  // ---------------------------------------------------------------------
  logic [31:0] w_mi32, w_ni32, w_ki32;
  logic [31:0] w_a_addr, w_b_addr, w_c_addr;

  assign w_mi32 = 32'(r_mi);
  assign w_ni32 = 32'(r_ni);
  assign w_ki32 = 32'(r_ki);

  assign w_a_addr = r_a_base + ((w_mi32 * 32'(r_stride_a)) << LOG2T) + (w_ki32 << LOG2T);
  assign w_b_addr = r_b_base + ((w_ki32 * 32'(r_stride_b)) << LOG2T) + (w_ni32 << LOG2T);
  // C elements are 4 bytes wide, hence the extra shift on the column offset.
  assign w_c_addr = r_c_base + ((w_mi32 * 32'(r_stride_c)) << LOG2T) + (w_ni32 << (LOG2T + 2));

  // ---------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------
`ifdef GEMM_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] r_wdog;
  logic             w_wait_phase;

  assign w_wait_phase = (r_state == LOAD_A_WAIT) || (r_state == LOAD_B_WAIT) ||
                        (r_state == COMPUTE)     || (r_state == STORE_C_WAIT);

  // Restarts on every phase change; only counts while waiting on a peer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if ((w_state_next != r_state) || !w_wait_phase) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Fire on the edge where the counter would reach all ones, so the job
  // leaves the phase exactly 2^TMO_W - 1 cycles after entering it.
  assign w_tmo = w_wait_phase && (r_wdog == {{(TMO_W-1){1'b1}}, 1'b0});
`else
  assign w_tmo = 1'b0;

  // TMO_W has no effect in this build; the empty block keeps it referenced.
  if (TMO_W < 1) begin : g_tmo_w_unused
  end
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state, index and status update
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_mi_next       = r_mi;
    w_ni_next       = r_ni;
    w_ki_next       = r_ki;
    w_error_next    = r_error;
    w_err_code_next = r_err_code;
    w_latch         = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_error_next    = 1'b0;
          w_err_code_next = ERR_NONE;
          w_mi_next       = '0;
          w_ni_next       = '0;
          w_ki_next       = '0;
          if ((m_dim == '0) || (k_dim == '0) || (n_dim == '0)) begin
            w_state_next    = ERR;
            w_error_next    = 1'b1;
            w_err_code_next = ERR_DIM;
          end else begin
            w_latch      = 1'b1;
            w_state_next = LOAD_A_ISSUE;
          end
        end
      end
      LOAD_A_ISSUE: if (dma_ack) w_state_next = LOAD_A_WAIT;
      LOAD_A_WAIT: begin
        if (dma_err) begin
          w_state_next    = ERR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_DMA;
        end else if (dma_done) begin
          w_state_next = LOAD_B_ISSUE;
        end
      end
      LOAD_B_ISSUE: if (dma_ack) w_state_next = LOAD_B_WAIT;
      LOAD_B_WAIT: begin
        if (dma_err) begin
          w_state_next    = ERR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_DMA;
        end else if (dma_done) begin
          w_state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (comp_done) begin
          if (r_ki == r_kt - DIM_W'(1)) begin
            w_state_next = STORE_C_ISSUE;
          end else begin
            w_ki_next    = r_ki + DIM_W'(1);
            w_state_next = LOAD_A_ISSUE;
          end
        end
      end
      STORE_C_ISSUE: if (dma_ack) w_state_next = STORE_C_WAIT;
      STORE_C_WAIT: begin
        if (dma_err) begin
          w_state_next    = ERR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_DMA;
        end else if (dma_done) begin
          w_ki_next = '0;
          if (r_ni == r_nt - DIM_W'(1)) begin
            w_ni_next = '0;
            if (r_mi == r_mt - DIM_W'(1)) begin
              w_state_next = DONE;
            end else begin
              w_mi_next    = r_mi + DIM_W'(1);
              w_state_next = LOAD_A_ISSUE;
            end
          end else begin
            w_ni_next    = r_ni + DIM_W'(1);
            w_state_next = LOAD_A_ISSUE;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (w_tmo) begin
      w_state_next    = ERR;
      w_error_next    = 1'b1;
      w_err_code_next = ERR_ABORT;
    end

    // Abort wins over everything once a job is running. ERR is already on
    // its way back to IDLE, so it is left alone.
    if (abort && (r_state != IDLE) && (r_state != ERR)) begin
      w_state_next    = ERR;
      w_error_next    = 1'b1;
      w_err_code_next = ERR_ABORT;
    end
  end

  // comp_start is registered so it appears in the first COMPUTE cycle.
  assign w_enter_compute = (w_state_next == COMPUTE) && (r_state != COMPUTE);

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_base     <= '0;
      r_b_base     <= '0;
      r_c_base     <= '0;
      r_stride_a   <= '0;
      r_stride_b   <= '0;
      r_stride_c   <= '0;
      r_mt         <= '0;
      r_nt         <= '0;
      r_kt         <= '0;
      r_mi         <= '0;
      r_ni         <= '0;
      r_ki         <= '0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_comp_start <= 1'b0;
      r_comp_clear <= 1'b0;
    end else begin
      if (w_latch) begin
        r_a_base   <= a_base;
        r_b_base   <= b_base;
        r_c_base   <= c_base;
        r_stride_a <= stride_a;
        r_stride_b <= stride_b;
        r_stride_c <= stride_c;
        r_mt       <= ceil_tiles(m_dim);
        r_nt       <= ceil_tiles(n_dim);
        r_kt       <= ceil_tiles(k_dim);
      end
      r_mi         <= w_mi_next;
      r_ni         <= w_ni_next;
      r_ki         <= w_ki_next;
      r_error      <= w_error_next;
      r_err_code   <= w_err_code_next;
      r_comp_start <= w_enter_compute;
      r_comp_clear <= w_enter_compute && (w_ki_next == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign comp_start = r_comp_start;
  assign comp_clear = r_comp_clear;
  assign tile_m     = r_mi;
  assign tile_n     = r_ni;
  assign tile_k     = r_ki;

  // Command fields come only from latched registers and indices, which do
  // not change during ISSUE, so they stay stable while waiting for ack.
  always_comb begin
    dma_req      = 1'b0;
    dma_dir      = 1'b0;
    dma_mem_addr = '0;
    dma_sp_addr  = '0;
    dma_len      = '0;
    dma_stride   = '0;
    case (r_state)
      LOAD_A_ISSUE, LOAD_A_WAIT: begin
        dma_req      = (r_state == LOAD_A_ISSUE);
        dma_mem_addr = w_a_addr;
        dma_sp_addr  = SP_A;
        dma_len      = LEN;
        dma_stride   = r_stride_a;
      end
      LOAD_B_ISSUE, LOAD_B_WAIT: begin
        dma_req      = (r_state == LOAD_B_ISSUE);
        dma_mem_addr = w_b_addr;
        dma_sp_addr  = SP_B;
        dma_len      = LEN;
        dma_stride   = r_stride_b;
      end
      STORE_C_ISSUE, STORE_C_WAIT: begin
        dma_req      = (r_state == STORE_C_ISSUE);
        dma_dir      = 1'b1;
        dma_mem_addr = w_c_addr;
        dma_sp_addr  = SP_C;
        dma_len      = LEN;
        dma_stride   = r_stride_c;
      end
      default: begin
      end
    endcase
  end

endmodule
